// File: rtl/io_periph_if.sv
// Load/store bus between a CPU-side master and the memory-mapped IO peripheral block.
// Signal names keep the peripheral's point of view (i_ = into the peripheral).
interface io_periph_if;
    logic        i_st_en;
    logic        i_ld_en;
    logic [11:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_bmask;
    logic [31:0] o_rdata;
    logic        o_rvalid;

    modport master (
        output i_st_en, i_ld_en, i_addr, i_wdata, i_bmask,
        input  o_rdata, o_rvalid
    );

    modport slave (
        input  i_st_en, i_ld_en, i_addr, i_wdata, i_bmask,
        output o_rdata, o_rvalid
    );
endinterface

// File: rtl/io_periph.sv
// Memory-mapped IO block: LED/LCD/seven-segment registers, debounced switches,
// byte-masked stores and single-cycle-latency loads.
module io_periph #(
    parameter int NUM_HEX    = 8,
    parameter int SW_W       = 32,
    parameter int DEB_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    io_periph_if.slave           bus,
    input  logic [SW_W-1:0]      i_io_sw,
    output logic [31:0]          o_io_ledr,
    output logic [31:0]          o_io_ledg,
    output logic [31:0]          o_io_lcd,
    output logic [7*NUM_HEX-1:0] o_io_hex
);

    localparam logic [9:0]  WA_LEDR    = 10'h000;
    localparam logic [9:0]  WA_LEDG    = 10'h004;
    localparam logic [9:0]  WA_HEX_LO  = 10'h008;
    localparam logic [9:0]  WA_HEX_HI  = 10'h009;
    localparam logic [9:0]  WA_LCD     = 10'h00C;
    localparam logic [9:0]  WA_HEXMODE = 10'h010;
    localparam logic [9:0]  WA_SW      = 10'h200;
    localparam logic [15:0] DEB_LAST   = 16'(DEB_CYCLES - 1);

    logic [31:0]     ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
    logic [7:0]      hexmode_q, hexmode_d;
    logic [6:0]      hex_q [8];
    logic [6:0]      hex_d [8];
    logic [SW_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [SW_W-1:0] cand_q, cand_d, deb_q, deb_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [9:0]      word;
    logic [31:0]     sw_ext;
    logic [1:0]      addr_unused;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_val;
        for (int k = 0; k < 4; k++)
            if (mask[k]) r[8*k +: 8] = new_val[8*k +: 8];
        return r;
    endfunction

    // Active-low segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: seg_decode = 7'h40;  4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;  4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;  4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;  4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;  4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;  4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;  4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;  default: seg_decode = 7'h0E;
        endcase
    endfunction

    assign word        = bus.i_addr[11:2];
    assign addr_unused = bus.i_addr[1:0];

    always_comb begin
        sw_ext             = '0;
        sw_ext[SW_W-1:0]   = deb_q;
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        ledr_d    = ledr_q;
        ledg_d    = ledg_q;
        lcd_d     = lcd_q;
        hexmode_d = hexmode_q;
        hex_d     = hex_q;
        rvalid_d  = 1'b0;
        rdata_d   = '0;

        if (bus.i_st_en) begin
            case (word)
                WA_LEDR: ledr_d = merge_bytes(ledr_q, bus.i_wdata, bus.i_bmask);
                WA_LEDG: ledg_d = merge_bytes(ledg_q, bus.i_wdata, bus.i_bmask);
                WA_LCD:  lcd_d  = merge_bytes(lcd_q,  bus.i_wdata, bus.i_bmask);
                WA_HEX_LO:
                    for (int i = 0; i < 4; i++)
                        if (i < NUM_HEX && bus.i_bmask[i]) hex_d[i] = bus.i_wdata[8*i +: 7];
                WA_HEX_HI:
                    for (int i = 0; i < 4; i++)
                        if (i + 4 < NUM_HEX && bus.i_bmask[i]) hex_d[i+4] = bus.i_wdata[8*i +: 7];
                WA_HEXMODE:
                    if (bus.i_bmask[0])
                        for (int i = 0; i < 8; i++)
                            if (i < NUM_HEX) hexmode_d[i] = bus.i_wdata[i];
                default: ;
            endcase
        end else if (bus.i_ld_en) begin
            // Reads see the pre-edge register contents; a concurrent store wins and drops the load.
            rvalid_d = 1'b1;
            case (word)
                WA_LEDR:    rdata_d = ledr_q;
                WA_LEDG:    rdata_d = ledg_q;
                WA_LCD:     rdata_d = lcd_q;
                WA_HEX_LO:
                    for (int i = 0; i < 4; i++)
                        if (i < NUM_HEX) rdata_d[8*i +: 7] = hex_q[i];
                WA_HEX_HI:
                    for (int i = 0; i < 4; i++)
                        if (i + 4 < NUM_HEX) rdata_d[8*i +: 7] = hex_q[i+4];
                WA_HEXMODE: rdata_d[7:0] = hexmode_q;
                WA_SW:      rdata_d = sw_ext;
                default:    rdata_d = '0;
            endcase
        end

        sync1_d = i_io_sw;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == DEB_LAST) begin
            deb_d = cand_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ledr_q    <= '0;
            ledg_q    <= '0;
            lcd_q     <= '0;
            hexmode_q <= '0;
            for (int i = 0; i < 8; i++) hex_q[i] <= 7'h7F;
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ledr_q    <= ledr_d;
            ledg_q    <= ledg_d;
            lcd_q     <= lcd_d;
            hexmode_q <= hexmode_d;
            hex_q     <= hex_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cand_q    <= cand_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.o_rdata  = rdata_q;
    assign bus.o_rvalid = rvalid_q;
    assign o_io_ledr    = ledr_q;
    assign o_io_ledg    = ledg_q;
    assign o_io_lcd     = lcd_q;

    for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
        assign o_io_hex[7*g +: 7] = hexmode_q[g] ? seg_decode(hex_q[g][3:0]) : hex_q[g];
    end

endmodule
